// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx, uart_tx and the receive buffer.
// Contents:
//   UART_BITS_PER_CHAR - framed character length (start + 8 data + stop)
//   timer_state_e      - idle character timeout FSM encoding
//   bit_time_cycles()  - clocks per bit, rounded to nearest
package uart_pkg;

    localparam int unsigned UART_BITS_PER_CHAR = 32'd10;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_COUNT   = 2'd1,
        T_EXPIRED = 2'd2
    } timer_state_e;

    // Rounded (not truncated) so the bit period error stays within half a clock.
    function automatic int unsigned bit_time_cycles(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
        return (clk_freq + (baud_rate / 32'd2)) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Idle character timeout for the receive buffer.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   activity      a push or pop takes effect this cycle
//   nonempty      the buffer will hold data after this cycle
//   flush         buffer contents are being discarded this cycle
//   o_timeout     data has sat untouched for LIMIT cycles
module uart_idle_timer
    import uart_pkg::*;
#(
    parameter int unsigned LIMIT = 32'd200
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic activity,
    input  logic nonempty,
    input  logic flush,
    output logic o_timeout
);

    localparam int CW = $clog2(LIMIT) + 1;

    timer_state_e   state_r;
    logic [CW-1:0]  count_r;
    logic           timeout_r;

    // Timer FSM, counter and registered timeout flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= T_IDLE;
            count_r   <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else if (flush || !nonempty) begin
            state_r   <= T_IDLE;
            count_r   <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else if (activity) begin
            state_r   <= T_COUNT;
            count_r   <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            case (state_r)
                T_IDLE: begin
                    state_r   <= T_COUNT;
                    count_r   <= {CW{1'b0}};
                    timeout_r <= 1'b0;
                end
                T_COUNT: begin
                    // Counter parks at LIMIT-1 on expiry, so it can never wrap.
                    if (count_r == CW'(LIMIT - 32'd1)) begin
                        state_r   <= T_EXPIRED;
                        timeout_r <= 1'b1;
                    end else begin
                        count_r   <= count_r + CW'(1);
                        timeout_r <= 1'b0;
                    end
                end
                T_EXPIRED: begin
                    timeout_r <= 1'b1;
                end
                default: begin
                    state_r   <= T_IDLE;
                    count_r   <= {CW{1'b0}};
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_timeout = timeout_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: first-word-fall-through FIFO with
// valid/ready read side, level/almost-full/sticky-overflow status and an
// idle character timeout.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_wr_data, i_wr_valid  received byte and its one-cycle strobe (no backpressure)
//   o_rd_data, o_rd_valid  head byte and non-empty flag
//   i_rd_ready             consumer takes the head byte
//   i_flush                discard everything stored
//   i_clr_overflow         clear sticky overflow
//   o_level, o_empty, o_full, o_almost_full, o_overflow, o_timeout  status
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH         = 32'd16,
    parameter int unsigned AF_THRESH     = 32'd12,
    parameter int unsigned CLK_FREQ      = 32'd80_000_000,
    parameter int unsigned BAUD_RATE     = 32'd115200,
    parameter int unsigned TIMEOUT_CHARS = 32'd4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_wr_data,
    input  logic                       i_wr_valid,
    output logic [7:0]                 o_rd_data,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    input  logic                       i_flush,
    input  logic                       i_clr_overflow,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_almost_full,
    output logic                       o_overflow,
    output logic                       o_timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int unsigned LIMIT =
        TIMEOUT_CHARS * UART_BITS_PER_CHAR * bit_time_cycles(CLK_FREQ, BAUD_RATE);

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_next_s;
    logic          overflow_r;
    logic          rd_valid_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_event_s;

    assign rd_valid_s = (level_r != {LW{1'b0}});
    assign full_s     = (level_r == LW'(DEPTH));

    // Handshake decode and next occupancy; flush overrides any transfer.
    always_comb begin
        pop_s        = rd_valid_s && i_rd_ready;
        push_s       = i_wr_valid && (!full_s || pop_s);
        ovf_event_s  = i_wr_valid && full_s && !pop_s && !i_flush;
        level_next_s = level_r;
        if (i_flush) begin
            level_next_s = {LW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_next_s = level_r + LW'(1);
                2'b01:   level_next_s = level_r - LW'(1);
                default: level_next_s = level_r;
            endcase
        end
    end

    // Storage array write port; contents need no reset since level gates reads.
    always_ff @(posedge i_clk) begin
        if (push_s && !i_flush) begin
            mem_r[wr_ptr_r] <= i_wr_data;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r <= level_next_s;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_r <= 1'b0;
        end else if (ovf_event_s) begin
            overflow_r <= 1'b1;
        end else if (i_clr_overflow) begin
            overflow_r <= 1'b0;
        end
    end

    uart_idle_timer #(
        .LIMIT(LIMIT)
    ) u_idle_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .activity  ((push_s || pop_s) && !i_flush),
        .nonempty  (level_next_s != {LW{1'b0}}),
        .flush     (i_flush),
        .o_timeout (o_timeout)
    );

    // Head byte reads as zero while empty so reset and flush present 8'h00.
    assign o_rd_data     = rd_valid_s ? mem_r[rd_ptr_r] : 8'h00;
    assign o_rd_valid    = rd_valid_s;
    assign o_level       = level_r;
    assign o_empty       = !rd_valid_s;
    assign o_full        = full_s;
    assign o_almost_full = (level_r >= LW'(AF_THRESH));
    assign o_overflow    = overflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       flush;
    logic       clr_ovf;
    logic [2:0] level;
    logic       empty, full, almost_full, overflow, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH(4), .AF_THRESH(3), .CLK_FREQ(1_000_000),
        .BAUD_RATE(100_000), .TIMEOUT_CHARS(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_data(wr_data), .i_wr_valid(wr_valid),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
        .i_flush(flush), .i_clr_overflow(clr_ovf), .o_level(level),
        .o_empty(empty), .o_full(full), .o_almost_full(almost_full),
        .o_overflow(overflow), .o_timeout(timeout)
    );

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        logic [2:0] lvl;
        logic [7:0] dout;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    endtask

    // Full status check derived from expected level / head / overflow / timeout.
    task automatic chk_state(input string tag, input logic [2:0] lvl, input logic [7:0] dout,
                             input logic ovf, input logic to);
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".valid"}, 32'(rd_valid), 32'(lvl != 3'd0));
        chk({tag, ".data"},  32'(rd_data), 32'(dout));
        chk({tag, ".empty"}, 32'(empty), 32'(lvl == 3'd0));
        chk({tag, ".full"},  32'(full), 32'(lvl == 3'd4));
        chk({tag, ".af"},    32'(almost_full), 32'(lvl >= 3'd3));
        chk({tag, ".ovf"},   32'(overflow), 32'(ovf));
        chk({tag, ".to"},    32'(timeout), 32'(to));
    endtask

    task automatic add(input logic wr, input logic [7:0] din, input logic rdy, input logic clr,
                       input logic [2:0] lvl, input logic [7:0] dout, input logic ovf);
        vec_t v;
        v.wr = wr; v.din = din; v.rdy = rdy; v.clr = clr; v.lvl = lvl; v.dout = dout; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1; wr_data = d; tick(); idle_inputs();
    endtask

    task automatic pop();
        rd_ready = 1'b1; tick(); idle_inputs();
    endtask

    // Returns edges elapsed until o_timeout is seen, capped at the bound.
    task automatic edges_to_timeout(input int bound, output int edges);
        edges = 0;
        while (!timeout && edges < bound) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int e;
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        chk_state("reset", 3'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // 1: ordered fill, almost-full, FWFT drain
        add(1, 8'h11, 0, 0, 3'd1, 8'h11, 0);
        add(1, 8'h22, 0, 0, 3'd2, 8'h11, 0);
        add(1, 8'h33, 0, 0, 3'd3, 8'h11, 0);
        add(0, 8'h00, 1, 0, 3'd2, 8'h22, 0);
        add(0, 8'h00, 1, 0, 3'd1, 8'h33, 0);
        add(0, 8'h00, 1, 0, 3'd0, 8'h00, 0);
        // 2: overflow drops FF, contents intact, clear
        add(1, 8'hA0, 0, 0, 3'd1, 8'hA0, 0);
        add(1, 8'hA1, 0, 0, 3'd2, 8'hA0, 0);
        add(1, 8'hA2, 0, 0, 3'd3, 8'hA0, 0);
        add(1, 8'hA3, 0, 0, 3'd4, 8'hA0, 0);
        add(1, 8'hFF, 0, 0, 3'd4, 8'hA0, 1);
        add(0, 8'h00, 1, 0, 3'd3, 8'hA1, 1);
        add(0, 8'h00, 1, 0, 3'd2, 8'hA2, 1);
        add(0, 8'h00, 1, 0, 3'd1, 8'hA3, 1);
        add(0, 8'h00, 1, 0, 3'd0, 8'h00, 1);
        add(0, 8'h00, 0, 1, 3'd0, 8'h00, 0);
        // 3: push+pop while full
        add(1, 8'hB0, 0, 0, 3'd1, 8'hB0, 0);
        add(1, 8'hB1, 0, 0, 3'd2, 8'hB0, 0);
        add(1, 8'hB2, 0, 0, 3'd3, 8'hB0, 0);
        add(1, 8'hB3, 0, 0, 3'd4, 8'hB0, 0);
        add(1, 8'h55, 1, 0, 3'd4, 8'hB1, 0);
        add(0, 8'h00, 1, 0, 3'd3, 8'hB2, 0);
        add(0, 8'h00, 1, 0, 3'd2, 8'hB3, 0);
        add(0, 8'h00, 1, 0, 3'd1, 8'h55, 0);
        add(0, 8'h00, 1, 0, 3'd0, 8'h00, 0);
        // empty FIFO: same-cycle push and ready must not pop
        add(1, 8'h66, 1, 0, 3'd1, 8'h66, 0);
        add(0, 8'h00, 1, 0, 3'd0, 8'h00, 0);
        // overflow and clear in the same cycle: set wins
        add(1, 8'hC0, 0, 0, 3'd1, 8'hC0, 0);
        add(1, 8'hC1, 0, 0, 3'd2, 8'hC0, 0);
        add(1, 8'hC2, 0, 0, 3'd3, 8'hC0, 0);
        add(1, 8'hC3, 0, 0, 3'd4, 8'hC0, 0);
        add(1, 8'hEE, 0, 1, 3'd4, 8'hC0, 1);
        add(0, 8'h00, 1, 1, 3'd3, 8'hC1, 0);
        add(0, 8'h00, 1, 0, 3'd2, 8'hC2, 0);
        add(0, 8'h00, 1, 0, 3'd1, 8'hC3, 0);
        add(0, 8'h00, 1, 0, 3'd0, 8'h00, 0);

        foreach (vecs[i]) begin
            wr_valid = vecs[i].wr; wr_data = vecs[i].din;
            rd_ready = vecs[i].rdy; clr_ovf = vecs[i].clr;
            tick();
            chk_state($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].dout, vecs[i].ovf, 1'b0);
        end
        idle_inputs();

        // 4: timeout 200 edges after the push edge, drops after a pop
        push(8'h77);
        edges_to_timeout(400, e);
        chk("t4.rise_edges", 32'(e), 32'd200);
        pop();
        chk_state("t4.after_pop", 3'd0, 8'h00, 1'b0, 1'b0);
        edges_to_timeout(300, e);
        chk("t4.idle_no_timeout", 32'(e), 32'd300);

        // 5: a second push at edge 150 restarts the count
        push(8'h81);
        repeat (149) tick();
        chk("t5.no_early_timeout", 32'(timeout), 32'd0);
        push(8'h82);
        edges_to_timeout(400, e);
        chk("t5.rise_edges", 32'(e), 32'd200);
        pop();
        chk_state("t5.pop_drops_to", 3'd1, 8'h82, 1'b0, 1'b0);
        pop();
        chk_state("t5.drained", 3'd0, 8'h00, 1'b0, 1'b0);

        // 6: flush with concurrent push at level 3, overflow preserved
        push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3); push(8'hDF);
        chk("t6.ovf_set", 32'(overflow), 32'd1);
        pop();
        chk_state("t6.level3", 3'd3, 8'hD1, 1'b1, 1'b0);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
        tick(); idle_inputs();
        chk_state("t6.flushed", 3'd0, 8'h00, 1'b1, 1'b0);
        push(8'h12);
        chk_state("t6.post_flush", 3'd1, 8'h12, 1'b1, 1'b0);

        // reset mid-fill with a write in flight
        push(8'h13);
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h14;
        tick(); idle_inputs(); rst = 1'b0;
        chk_state("t6.reset", 3'd0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of uart_rx. It captures each single-cycle received-byte pulse into a first-word-fall-through FIFO and presents bytes to the processor-side consumer through a valid/ready handshake. It also provides level, almost-full and sticky-overflow status, plus a 16550-style idle character timeout. uart_rx has no backpressure, so this block must absorb bytes or flag their loss.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2
AF_THRESH, 12, o_almost_full asserts when level >= AF_THRESH
CLK_FREQ, 80_000_000, clock frequency in Hz
BAUD_RATE, 115200, line rate in baud
TIMEOUT_CHARS, 4, idle character times before o_timeout; minimum 1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_wr_data  in  8  received byte; connects to uart_rx o_data
i_wr_valid  in  1  one-cycle pulse, byte valid; connects to uart_rx o_data_valid
o_rd_data  out  8  head-of-FIFO byte (FWFT)
o_rd_valid  out  1  FIFO non-empty
i_rd_ready  in  1  consumer accepts o_rd_data
i_flush  in  1  discard all contents
i_clr_overflow  in  1  clear sticky overflow
o_level  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
o_empty  out  1  level == 0
o_full  out  1  level == DEPTH
o_almost_full  out  1  level >= AF_THRESH
o_overflow  out  1  sticky: a byte was dropped
o_timeout  out  1  idle timeout expired with data pending

Behaviour:
- Reset: i_clk and i_rst as decided above (synchronous, active-high).
  - Pointers and level = 0; o_empty = 1; o_rd_valid, o_full, o_almost_full, o_overflow, o_timeout = 0; o_rd_data = 8'h00.
  - Timer state goes to T_IDLE.
  - Reset mid-transfer discards all contents.
- Storage: DEPTH x 8 register array; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally; level is a separate registered counter.
- Pop: occurs when o_rd_valid && i_rd_ready. The next entry appears on o_rd_data the following cycle.
- Push: occurs when i_wr_valid && (!full || pop in the same cycle).
  - Write-to-o_rd_valid latency is 1 cycle.
  - On an empty FIFO, a same-cycle push and ready does not pop.
- Full, with i_wr_valid and no pop: byte dropped, contents unchanged, o_overflow set.
- Full, with simultaneous push and pop: both happen; level stays DEPTH; no overflow.
- o_overflow: cleared by i_clr_overflow. If an overflow occurs in the same cycle as i_clr_overflow, set wins. Not affected by i_flush.
- i_flush: next cycle, pointers and level = 0 and o_timeout = 0. Flush has priority over a same-cycle push or pop; that byte is discarded and does not count as overflow.
- Status outputs: all derived from registered level and valid in the same cycle as o_level.
- Timeout timer:
  - bit_time = (CLK_FREQ + BAUD_RATE/2)/BAUD_RATE.
  - limit = TIMEOUT_CHARS*10*bit_time (10 bits per character).
  - States:
    - T_IDLE: FIFO empty; counter = 0.
    - T_COUNT: non-empty; counter increments each cycle. Any push or pop resets the counter to 0 and stays in T_COUNT.
    - T_EXPIRED: entered when counter == limit-1 with no push/pop that cycle; o_timeout = 1 from the next cycle.
  - Push or pop in T_COUNT or T_EXPIRED → T_COUNT with counter 0, and o_timeout drops the following cycle.
  - FIFO becoming empty, or flush → T_IDLE.
  - Counter width is $clog2(limit)+1 and it never wraps.

Decomposition:
- Shared package uart_pkg:
  - UART_BITS_PER_CHAR = 10
  - bit-time rounding function (shared with uart_rx/uart_tx)
  - timer state encoding: T_IDLE=2'd0, T_COUNT=2'd1, T_EXPIRED=2'd2
- Sub-module uart_idle_timer: timer FSM plus counter, with inputs activity, nonempty, flush and output o_timeout. The FIFO core stays in uart_rx_fifo.

Test Plan:
Bench parameters: DEPTH=4, AF_THRESH=3, CLK_FREQ=1_000_000, BAUD_RATE=100_000, TIMEOUT_CHARS=2, giving limit = 200 cycles.
1. Push 8'h11, 8'h22, 8'h33 with ready=0 → o_level 1,2,3 on successive cycles; o_almost_full=1 at level 3. Then ready=1 → reads 11, 22, 33 in order; o_empty=1 after the third pop.
2. Fill 4 bytes (A0..A3), push 8'hFF with no pop → o_full=1, o_overflow=1, reads A0..A3, FF never appears. i_clr_overflow → o_overflow=0 next cycle.
3. Full FIFO, same-cycle push 8'h55 and pop → level stays 4, no overflow, 8'h55 read last.
4. Push one byte, no activity → o_timeout rises exactly 200 cycles after the push cycle (201st cycle). Pop → o_timeout=0 next cycle, T_IDLE.
5. Push a byte at cycle 0, push another at cycle 150 → o_timeout first asserts 200 cycles after cycle 150, not cycle 200.
6. Level 3 with i_flush asserted together with i_wr_valid → next cycle o_level=0, o_empty=1, o_overflow unchanged, pushed byte discarded. Reset mid-fill → all outputs at reset values next cycle.
